instruction_memory_loadable: RTL and testbench
==============================================

Name: instruction_memory_loadable

Overview:
Parametrised instruction store for the single-cycle/multi-cycle CPU.
- Replaces the hard-coded combinational program ROM with a RAM-backed memory and a synchronous fetch port.
- A streaming load port lets the testbench or a boot controller write a program at run time.
- A clear sequence after reset zeroes the array; the all-zero word is the NOP encoding.

Parameters:
DATA_WIDTH, 32, instruction word width in bits (opcode[DW-1:DW-3], rs, rt, rd/imm fields unchanged).
ADDR_WIDTH, 5, fetch/load address width.
DEPTH, 32, number of implemented words; must be 1..2**ADDR_WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
load_start  input  1  request to begin a program load (sampled in IDLE only).
load_valid  input  1  load_data holds a word to write.
load_last  input  1  qualifies load_valid: this word is the final one.
load_data  input  DATA_WIDTH  program word.
load_ready  output  1  memory accepts a load word this cycle.
load_done  output  1  one-cycle pulse when a load completes.
load_count  output  ADDR_WIDTH+1  words written by the most recent load.
fetch_req  input  1  fetch request.
fetch_addr  input  ADDR_WIDTH  word address.
fetch_ready  output  1  fetch port accepts requests (IDLE only).
instruction  output  DATA_WIDTH  fetched word, registered.
instruction_valid  output  1  one-cycle pulse: instruction updated this cycle.
addr_error  output  1  accompanies instruction_valid when fetch_addr >= DEPTH.

Behaviour:
- Reset (synchronous, any state, including mid-load and mid-clear):
  - Outputs go to: state=CLEAR, clear pointer=0, instruction=0, instruction_valid=0, addr_error=0, load_ready=0, load_done=0, load_count=0, fetch_ready=0.
- States: CLEAR, IDLE, LOAD.
- CLEAR:
  - Writes 0 to mem[ptr] each cycle and increments ptr.
  - After writing DEPTH-1, moves to IDLE, so CLEAR lasts exactly DEPTH cycles after reset deasserts.
  - fetch_ready=0 and load_ready=0 throughout; load_start is ignored.
- IDLE:
  - fetch_ready=1, load_ready=0.
  - When load_start=1: go to LOAD, load pointer=0, load_count=0.
- LOAD:
  - load_ready=1, fetch_ready=0.
  - Handshake: each cycle with load_valid=1, mem[ptr]=load_data, ptr+1, load_count+1.
  - Load ends, returning to IDLE with load_done=1 in the following cycle, when either:
    - load_valid && load_last, or
    - the word written is at ptr=DEPTH-1.
  - load_start while in LOAD is ignored.
  - load_valid while not in LOAD is ignored; memory is unchanged.
  - Words beyond the last loaded address keep their previous contents.
  - load_count holds its value until the next load_start or reset.
- Fetch:
  - When fetch_req && fetch_ready at edge N, then at edge N+1: instruction = mem[fetch_addr] and instruction_valid=1 for that cycle. Latency is 1 cycle, and back-to-back fetches give one word per cycle.
  - Without an accepted request, instruction holds its last value and instruction_valid=0.
  - Out-of-range address (fetch_addr >= DEPTH): instruction=0 (NOP), instruction_valid=1, addr_error=1. addr_error is otherwise 0.
  - fetch_req while fetch_ready=0 is dropped, not queued.
- Simultaneous events:
  - load_start and fetch_req together in IDLE: the fetch is accepted and served at N+1, and the state enters LOAD at N+1.
  - load_done returns to IDLE; a fetch may be accepted in the cycle load_done is high.
- Width rules:
  - load_count is ADDR_WIDTH+1 bits so that DEPTH=2**ADDR_WIDTH fits.
  - The pointer never exceeds DEPTH-1, with no wrap-around.
- Storage is one memory array with a single write port shared by the CLEAR and LOAD paths and one synchronous read port. The write mux is selected by state, so there are never simultaneous writes.

Test Plan:
- Reset then clear: hold reset 2 cycles, release.
  - Required: fetch_ready=0 for exactly 32 cycles, then 1.
  - Fetching addr 0..31 returns 0x00000000, with addr_error=0.
- Load program: load_start, then stream 0xC00A000A (ADDI r10,r0,10), 0xC00F000F (ADDI r15,r0,15), and 0x4A7E4000 (ADD r25,r10,r15) with load_last on the third word.
  - Required: load_done one cycle after the third word, load_count=3.
  - Fetch addr 2 gives 0x4A7E4000 exactly one cycle later, with instruction_valid=1.
- Gapped load / overflow:
  - Toggle load_valid with idle gaps; only valid cycles write.
  - Stream 40 words without load_last: exactly 32 are written, load_done fires after word 32, load_count=32, and the remaining 8 beats see load_ready=0.
- Out-of-range fetch with DEPTH=20, ADDR_WIDTH=5:
  - fetch addr 25 -> instruction=0, addr_error=1.
  - fetch addr 19 -> stored word, addr_error=0.
- Simultaneous and ignored requests:
  - load_start with fetch_req(addr 1) in IDLE -> next cycle instruction=0xC00F000F, valid=1, state LOAD.
  - fetch_req during LOAD -> no instruction_valid.
- Reset mid-load:
  - Assert reset after 2 of 5 load words -> CLEAR restarts, load_done never pulses, load_count=0.
  - All addresses read 0 after 32 cycles.

Source files
------------

// File: rtl/instruction_memory_loadable.sv
// RAM-backed instruction store: clears itself after reset, accepts a streamed
// program load, and serves one registered fetch per cycle while idle.
module instruction_memory_loadable #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic                  load_last,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   output logic                  load_done,
   output logic [ADDR_WIDTH:0]   load_count,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_ready,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  instruction_valid,
   output logic                  addr_error
);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
   logic                  load_ready_q;
   logic                  load_done_q;
   logic                  fetch_ready_q;
   logic                  instruction_valid_q;
   logic                  addr_error_q;
   logic                  rd_zero_q;
   logic [DATA_WIDTH-1:0] rd_data_q;

   logic                  ptr_at_end;
   logic                  load_end;
   logic                  fetch_accept;
   logic                  fetch_in_range;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;

   assign ptr_at_end     = (ptr_q == LAST_PTR);
   assign load_end       = (state_q == ST_LOAD) && load_valid && (load_last || ptr_at_end);
   assign fetch_accept   = fetch_req && fetch_ready_q;
   assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_W);
   assign rd_idx         = fetch_in_range ? fetch_addr : '0;

   // Single write port: CLEAR writes zeros, LOAD writes the streamed word.
   always_comb begin
      wr_en   = 1'b0;
      wr_data = '0;
      if (!reset) begin
         case (state_q)
            ST_CLEAR: wr_en = 1'b1;
            ST_LOAD: begin
               wr_en   = load_valid;
               wr_data = load_data;
            end
            default: wr_en = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      load_count_d = load_count_q;
      case (state_q)
         ST_CLEAR: begin
            if (ptr_at_end) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (load_start) begin
               state_d      = ST_LOAD;
               ptr_d        = '0;
               load_count_d = '0;
            end
         end
         ST_LOAD: begin
            if (load_valid) begin
               load_count_d = load_count_q + 1'b1;
               if (load_end) begin
                  state_d = ST_IDLE;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= ST_CLEAR;
         ptr_q               <= '0;
         load_count_q        <= '0;
         load_ready_q        <= 1'b0;
         load_done_q         <= 1'b0;
         fetch_ready_q       <= 1'b0;
         instruction_valid_q <= 1'b0;
         addr_error_q        <= 1'b0;
         rd_zero_q           <= 1'b1;
      end else begin
         state_q             <= state_d;
         ptr_q               <= ptr_d;
         load_count_q        <= load_count_d;
         load_ready_q        <= (state_d == ST_LOAD);
         load_done_q         <= load_end;
         fetch_ready_q       <= (state_d == ST_IDLE);
         instruction_valid_q <= fetch_accept;
         addr_error_q        <= fetch_accept && !fetch_in_range;
         if (fetch_accept) begin
            rd_zero_q <= !fetch_in_range;
         end
      end
   end

   // Array ports kept free of reset so the storage maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (fetch_accept) begin
         rd_data_q <= mem[rd_idx];
      end
   end

   assign instruction       = rd_zero_q ? '0 : rd_data_q;
   assign instruction_valid = instruction_valid_q;
   assign addr_error        = addr_error_q;
   assign load_ready        = load_ready_q;
   assign load_done         = load_done_q;
   assign load_count        = load_count_q;
   assign fetch_ready       = fetch_ready_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench: a full-depth instance and a DEPTH=20 instance share stimulus.
module tb_instruction_memory_loadable;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_start, load_valid, load_last;
   logic [31:0] load_data;
   logic        fetch_req;
   logic [4:0]  fetch_addr;

   logic        a_load_ready, a_load_done, a_fetch_ready, a_instruction_valid, a_addr_error;
   logic [5:0]  a_load_count;
   logic [31:0] a_instruction;
   logic        b_load_ready, b_load_done, b_fetch_ready, b_instruction_valid, b_addr_error;
   logic [5:0]  b_load_count;
   logic [31:0] b_instruction;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   instruction_memory_loadable #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32)) u_a (
      .clk(clk), .reset(reset),
      .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
      .load_data(load_data), .load_ready(a_load_ready), .load_done(a_load_done),
      .load_count(a_load_count), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(a_fetch_ready), .instruction(a_instruction),
      .instruction_valid(a_instruction_valid), .addr_error(a_addr_error)
   );

   instruction_memory_loadable #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(20)) u_b (
      .clk(clk), .reset(reset),
      .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
      .load_data(load_data), .load_ready(b_load_ready), .load_done(b_load_done),
      .load_count(b_load_count), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(b_fetch_ready), .instruction(b_instruction),
      .instruction_valid(b_instruction_valid), .addr_error(b_addr_error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input logic [4:0] a);
      fetch_req  = 1'b1;
      fetch_addr = a;
      tick();
      fetch_req  = 1'b0;
   endtask

   task automatic word(input logic [31:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   // Watches 40 cycles after reset release: fetch_ready low-cycles and any load_done.
   task automatic watch_clear(input string tag);
      int za, zb, dn;
      za = 0; zb = 0; dn = 0;
      for (int c = 0; c < 40; c++) begin
         if (!a_fetch_ready) za++;
         if (!b_fetch_ready) zb++;
         if (a_load_done || b_load_done) dn++;
         tick();
      end
      chk({tag, "_a_cycles"}, za, 32);
      chk({tag, "_b_cycles"}, zb, 20);
      chk({tag, "_no_done"}, dn, 0);
   endtask

   task automatic read_all_zero(input string tag);
      logic err_b;
      for (int i = 0; i < 32; i++) begin
         fetch(5'(i));
         err_b = (i >= 20);
         chk($sformatf("%s_a[%0d]", tag, i),
             {a_instruction_valid, a_addr_error, a_instruction}, {1'b1, 1'b0, 32'h0});
         chk($sformatf("%s_b[%0d]", tag, i),
             {b_instruction_valid, b_addr_error, b_instruction}, {1'b1, err_b, 32'h0});
      end
   endtask

   initial begin
      int nr, da, db;
      reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      load_data = '0; fetch_req = 1'b0; fetch_addr = '0;
      tick();
      tick();
      chk("rst_a", {a_instruction, a_instruction_valid, a_addr_error, a_load_ready,
                    a_load_done, a_fetch_ready, a_load_count}, 64'h0);
      chk("rst_b", {b_instruction, b_instruction_valid, b_addr_error, b_load_ready,
                    b_load_done, b_fetch_ready, b_load_count}, 64'h0);
      reset = 1'b0;
      watch_clear("clr");
      read_all_zero("clr_rd");

      // Three-word program with load_last on the final word.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("ld_ready", {a_load_ready, a_fetch_ready}, 2'b10);
      word(32'hC00A000A, 1'b0);
      word(32'hC00F000F, 1'b0);
      chk("ld_not_done", a_load_done, 1'b0);
      word(32'h4A7E4000, 1'b1);
      chk("ld_done", {a_load_done, a_fetch_ready, a_load_ready}, 3'b110);
      chk("ld_cnt", a_load_count, 6'd3);
      fetch(5'd2);
      chk("prog_rd2", {a_instruction_valid, a_addr_error, a_instruction}, {1'b1, 1'b0, 32'h4A7E4000});
      chk("done_pulse", a_load_done, 1'b0);
      tick();
      chk("valid_pulse", a_instruction_valid, 1'b0);
      chk("instr_hold", a_instruction, 32'h4A7E4000);

      // load_start and fetch together in IDLE.
      load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 5'd1;
      tick();
      load_start = 1'b0; fetch_req = 1'b0;
      chk("sim_rd", {a_instruction_valid, a_instruction}, {1'b1, 32'hC00F000F});
      chk("sim_state", {a_load_ready, a_fetch_ready, a_load_count}, {2'b10, 6'd0});
      fetch_req = 1'b1; fetch_addr = 5'd0;
      tick();
      chk("ld_fetch_drop0", a_instruction_valid, 1'b0);
      tick();
      chk("ld_fetch_drop1", {a_instruction_valid, a_instruction}, {1'b0, 32'hC00F000F});
      fetch_req = 1'b0;

      // Gapped two-word load; address 2 keeps its previous word.
      word(32'hAAAA0001, 1'b0);
      load_data = 32'hDEADBEEF;
      tick();
      tick();
      word(32'hAAAA0002, 1'b1);
      chk("gap_done", {a_load_done, a_load_count}, {1'b1, 6'd2});
      fetch(5'd0);
      chk("gap_rd0", a_instruction, 32'hAAAA0001);
      fetch(5'd1);
      chk("gap_rd1", a_instruction, 32'hAAAA0002);
      fetch(5'd2);
      chk("gap_rd2", a_instruction, 32'h4A7E4000);

      // 40 beats without load_last: load stops at the last implemented word.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      nr = 0; da = -1; db = -1;
      for (int i = 0; i < 40; i++) begin
         load_valid = 1'b1;
         load_data  = 32'h1000 + i;
         if (!a_load_ready) nr++;
         tick();
         if (a_load_done) da = i;
         if (b_load_done) db = i;
      end
      load_valid = 1'b0;
      chk("ovf_not_ready", nr, 8);
      chk("ovf_done_a", da, 31);
      chk("ovf_done_b", db, 19);
      chk("ovf_cnt_a", a_load_count, 6'd32);
      chk("ovf_cnt_b", b_load_count, 6'd20);
      fetch(5'd19);
      chk("rd19_a", {a_instruction_valid, a_addr_error, a_instruction}, {1'b1, 1'b0, 32'h1013});
      chk("rd19_b", {b_instruction_valid, b_addr_error, b_instruction}, {1'b1, 1'b0, 32'h1013});
      fetch(5'd25);
      chk("rd25_a", {a_instruction_valid, a_addr_error, a_instruction}, {1'b1, 1'b0, 32'h1019});
      chk("rd25_b", {b_instruction_valid, b_addr_error, b_instruction}, {1'b1, 1'b1, 32'h0});
      fetch(5'd31);
      chk("rd31_a", {a_instruction_valid, a_addr_error, a_instruction}, {1'b1, 1'b0, 32'h101F});
      fetch(5'd0);
      chk("rd0_a", a_instruction, 32'h1000);
      chk("rd0_err", {a_addr_error, b_addr_error}, 2'b00);

      // Reset after two of five load words.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      word(32'h00000001, 1'b0);
      word(32'h00000002, 1'b0);
      load_valid = 1'b1; load_data = 32'h00000003; reset = 1'b1;
      tick();
      reset = 1'b0; load_valid = 1'b0;
      chk("mid_rst", {a_load_count, a_load_done, a_load_ready, a_fetch_ready}, 9'h0);
      watch_clear("mid_clr");
      read_all_zero("mid_rd");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
